// File: rtl/l2_bank_arb_pkg.sv
// l2_bank_arb_pkg: shared types for the L2 bank arbiter and its response pipeline
package l2_bank_arb_pkg;
  typedef enum logic {
    OWNER_A = 1'b0,
    OWNER_B = 1'b1
  } owner_e;
  typedef struct packed {
    logic   valid;
    owner_e owner;
  } rsp_tag_t;
endpackage

// File: rtl/l2_bank_arb_rsp_pipe.sv
// l2_bank_arb_rsp_pipe: LATENCY-deep shift register of read-response tags with sync active-low clear
module l2_bank_arb_rsp_pipe
  import l2_bank_arb_pkg::*;
#(
  parameter int unsigned LATENCY = 1
) (
  input  logic     clk_i,
  input  logic     rst_ni,
  input  rsp_tag_t tag_i,
  output rsp_tag_t tag_o
);
  rsp_tag_t [LATENCY-1:0] stage_q, stage_d;
  // shift new tag into stage 0, older tags move toward the tail
  always_comb begin
    stage_d[0] = tag_i;
    for (int i = 1; i < LATENCY; i++) stage_d[i] = stage_q[i-1];
  end
  // reset flushes every in-flight tag so no stale rvalid survives
  always_ff @(posedge clk_i) begin
    if (!rst_ni) stage_q <= '0;
    else stage_q <= stage_d;
  end
  assign tag_o = stage_q[LATENCY-1];
endmodule

// File: rtl/l2_bank_arbiter.sv
// l2_bank_arbiter: two-port (A primary, B secondary) arbiter for one L2 SRAM cut; optional stats via L2_BANK_ARBITER_STATS_EN
module l2_bank_arbiter
  import l2_bank_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 14,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned LATENCY    = 1,
  parameter int unsigned MAX_WAIT   = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    a_req_i,
  output logic                    a_gnt_o,
  input  logic [ADDR_WIDTH-1:0]   a_addr_i,
  input  logic                    a_we_i,
  input  logic [DATA_WIDTH-1:0]   a_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] a_be_i,
  output logic                    a_rvalid_o,
  output logic [DATA_WIDTH-1:0]   a_rdata_o,
  input  logic                    b_req_i,
  output logic                    b_gnt_o,
  input  logic [ADDR_WIDTH-1:0]   b_addr_i,
  input  logic                    b_we_i,
  input  logic [DATA_WIDTH-1:0]   b_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] b_be_i,
  output logic                    b_rvalid_o,
  output logic [DATA_WIDTH-1:0]   b_rdata_o,
  output logic                    mem_req_o,
  output logic                    mem_we_o,
  output logic [ADDR_WIDTH-1:0]   mem_addr_o,
  output logic [DATA_WIDTH-1:0]   mem_wdata_o,
  output logic [DATA_WIDTH/8-1:0] mem_be_o,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_i
`ifdef L2_BANK_ARBITER_STATS_EN
  ,
  output logic [31:0]             conflict_cnt_o,
  output logic [31:0]             starve_cnt_o
`endif
);
  localparam int unsigned WW = $clog2(MAX_WAIT + 1);
  logic [WW-1:0] wait_cnt_q, wait_cnt_d;
  logic          starved, b_win, a_win;
  rsp_tag_t      tag_in, tag_out;
  // B wins when alone or once it has lost MAX_WAIT times in a row; everything is muted in reset
  always_comb begin
    starved     = wait_cnt_q == WW'(MAX_WAIT);
    b_win       = rst_ni & b_req_i & (~a_req_i | starved);
    a_win       = rst_ni & a_req_i & ~b_win;
    a_gnt_o     = a_win;
    b_gnt_o     = b_win;
    mem_req_o   = a_win | b_win;
    mem_we_o    = a_win ? a_we_i    : b_win ? b_we_i    : 1'b0;
    mem_addr_o  = a_win ? a_addr_i  : b_win ? b_addr_i  : '0;
    mem_wdata_o = a_win ? a_wdata_i : b_win ? b_wdata_i : '0;
    mem_be_o    = a_win ? a_be_i    : b_win ? b_be_i    : '0;
    wait_cnt_d  = (b_req_i & ~b_win) ? wait_cnt_q + WW'(1) : '0;
    tag_in      = '{valid: mem_req_o & ~mem_we_o, owner: b_win ? OWNER_B : OWNER_A};
    a_rvalid_o  = rst_ni & tag_out.valid & (tag_out.owner == OWNER_A);
    b_rvalid_o  = rst_ni & tag_out.valid & (tag_out.owner == OWNER_B);
    a_rdata_o   = rst_ni ? mem_rdata_i : '0;
    b_rdata_o   = rst_ni ? mem_rdata_i : '0;
  end
  // consecutive-loss counter for B
  always_ff @(posedge clk_i) begin
    if (!rst_ni) wait_cnt_q <= '0;
    else wait_cnt_q <= wait_cnt_d;
  end
  l2_bank_arb_rsp_pipe #(.LATENCY(LATENCY)) u_rsp_pipe (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .tag_i  (tag_in),
    .tag_o  (tag_out)
  );
`ifdef L2_BANK_ARBITER_STATS_EN
  logic [31:0] conflict_cnt_q, conflict_cnt_d, starve_cnt_q, starve_cnt_d;
  // saturating event counters
  always_comb begin
    conflict_cnt_d = (a_req_i & b_req_i & ~&conflict_cnt_q) ? conflict_cnt_q + 32'd1 : conflict_cnt_q;
    starve_cnt_d   = (b_win & starved & ~&starve_cnt_q) ? starve_cnt_q + 32'd1 : starve_cnt_q;
  end
  // stats registers
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      conflict_cnt_q <= '0;
      starve_cnt_q   <= '0;
    end else begin
      conflict_cnt_q <= conflict_cnt_d;
      starve_cnt_q   <= starve_cnt_d;
    end
  end
  assign conflict_cnt_o = conflict_cnt_q;
  assign starve_cnt_o   = starve_cnt_q;
`endif
  a_lat_ok:   assert property (@(posedge clk_i) LATENCY >= 1);
  a_wait_ok:  assert property (@(posedge clk_i) MAX_WAIT >= 1);
  a_one_gnt:  assert property (@(posedge clk_i) !(a_gnt_o && b_gnt_o));
  a_one_rvld: assert property (@(posedge clk_i) !(a_rvalid_o && b_rvalid_o));
endmodule

// File: tb/tb_l2_bank_arbiter.sv
// tb_l2_bank_arbiter: directed checks of l2_bank_arbiter at LATENCY=1 (u1) and LATENCY=2 (u2)
module tb_l2_bank_arbiter;
  logic        clk_i = 0, rst_ni = 0;
  logic        a_req_i = 0, a_we_i = 0, b_req_i = 0, b_we_i = 0;
  logic [13:0] a_addr_i = 0, b_addr_i = 0;
  logic [63:0] a_wdata_i = 0, b_wdata_i = 0, mem_rdata_i = 0;
  logic [7:0]  a_be_i = 0, b_be_i = 0;
  logic        g1a, g1b, v1a, v1b, r1m, w1m, g2a, g2b, v2a, v2b, r2m, w2m;
  logic [13:0] ad1, ad2;
  logic [63:0] d1a, d1b, wd1, d2a, d2b, wd2;
  logic [7:0]  be1, be2;
  int checks = 0, failures = 0;
`ifdef L2_BANK_ARBITER_STATS_EN
  logic [31:0] cc1, sc1, cc2, sc2;
`endif
  always #5 clk_i = ~clk_i;
  l2_bank_arbiter #(.LATENCY(1)) u1 (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .a_req_i(a_req_i), .a_gnt_o(g1a), .a_addr_i(a_addr_i), .a_we_i(a_we_i), .a_wdata_i(a_wdata_i), .a_be_i(a_be_i),
    .a_rvalid_o(v1a), .a_rdata_o(d1a),
    .b_req_i(b_req_i), .b_gnt_o(g1b), .b_addr_i(b_addr_i), .b_we_i(b_we_i), .b_wdata_i(b_wdata_i), .b_be_i(b_be_i),
    .b_rvalid_o(v1b), .b_rdata_o(d1b),
    .mem_req_o(r1m), .mem_we_o(w1m), .mem_addr_o(ad1), .mem_wdata_o(wd1), .mem_be_o(be1), .mem_rdata_i(mem_rdata_i)
`ifdef L2_BANK_ARBITER_STATS_EN
    , .conflict_cnt_o(cc1), .starve_cnt_o(sc1)
`endif
  );
  l2_bank_arbiter #(.LATENCY(2)) u2 (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .a_req_i(a_req_i), .a_gnt_o(g2a), .a_addr_i(a_addr_i), .a_we_i(a_we_i), .a_wdata_i(a_wdata_i), .a_be_i(a_be_i),
    .a_rvalid_o(v2a), .a_rdata_o(d2a),
    .b_req_i(b_req_i), .b_gnt_o(g2b), .b_addr_i(b_addr_i), .b_we_i(b_we_i), .b_wdata_i(b_wdata_i), .b_be_i(b_be_i),
    .b_rvalid_o(v2b), .b_rdata_o(d2b),
    .mem_req_o(r2m), .mem_we_o(w2m), .mem_addr_o(ad2), .mem_wdata_o(wd2), .mem_be_o(be2), .mem_rdata_i(mem_rdata_i)
`ifdef L2_BANK_ARBITER_STATS_EN
    , .conflict_cnt_o(cc2), .starve_cnt_o(sc2)
`endif
  );
  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask
  function automatic bit b_turn(input int i);
    return i == 8 || i == 17;
  endfunction
  initial begin
    a_req_i = 1;
    a_addr_i = 14'h3ff;
    cyc();
    cyc();
    chk("rst_a_gnt", g1a, 0);
    chk("rst_mem_req", r1m, 0);
    chk("rst_mem_addr", ad1, 0);
    chk("rst_wait_cnt", u1.wait_cnt_q, 0);
    a_req_i = 0;
    rst_ni = 1;
    cyc();
    a_req_i = 1;
    a_addr_i = 14'h0010;
    #1;
    chk("t1_a_gnt", g1a, 1);
    chk("t1_b_gnt", g1b, 0);
    chk("t1_mem_req", r1m, 1);
    chk("t1_mem_addr", ad1, 14'h0010);
    chk("t1_mem_we", w1m, 0);
    cyc();
    a_req_i = 0;
    mem_rdata_i = 64'h1111_2222_3333_4444;
    #1;
    chk("t1_a_rvalid", v1a, 1);
    chk("t1_a_rdata", d1a, 64'h1111_2222_3333_4444);
    chk("t1_b_rvalid", v1b, 0);
    cyc();
    chk("t1_a_rvalid_off", v1a, 0);
    cyc();
    for (int i = 0; i < 20; i++) begin
      a_req_i = 1;
      b_req_i = 1;
      a_addr_i = 14'(i);
      b_addr_i = 14'(100 + i);
      #1;
      chk($sformatf("t2_a_gnt_%0d", i), g1a, !b_turn(i));
      chk($sformatf("t2_b_gnt_%0d", i), g1b, b_turn(i));
      chk($sformatf("t2_addr_%0d", i), ad1, b_turn(i) ? 14'(100 + i) : 14'(i));
      if (i > 0) begin
        chk($sformatf("t2_a_rvalid_%0d", i), v1a, !b_turn(i - 1));
        chk($sformatf("t2_b_rvalid_%0d", i), v1b, b_turn(i - 1));
      end
      cyc();
      if (b_turn(i)) chk($sformatf("t2_wait_clr_%0d", i), u1.wait_cnt_q, 0);
    end
    a_req_i = 0;
    b_req_i = 0;
    #1;
    chk("t2_wait_after", u1.wait_cnt_q, 2);
`ifdef L2_BANK_ARBITER_STATS_EN
    chk("t6_conflict", cc1, 20);
    chk("t6_starve", sc1, 2);
`endif
    cyc();
    cyc();
    for (int c = 0; c < 5; c++) begin
      a_req_i = c == 0 || c == 2;
      b_req_i = c == 1;
      a_addr_i = 14'(c + 1);
      b_addr_i = 14'(c + 1);
      mem_rdata_i = 64'(c) + 64'h50;
      #1;
      chk($sformatf("t3_a_rvalid_%0d", c), v2a, c == 2 || c == 4);
      chk($sformatf("t3_b_rvalid_%0d", c), v2b, c == 3);
      if (c == 3) chk("t3_b_rdata", d2b, 64'h53);
      cyc();
    end
    b_req_i = 1;
    b_we_i = 1;
    b_addr_i = 14'h0042;
    b_wdata_i = 64'hDEADBEEF;
    b_be_i = 8'hF0;
    #1;
    chk("t4_b_gnt", g1b, 1);
    chk("t4_mem_we", w1m, 1);
    chk("t4_mem_be", be1, 8'hF0);
    chk("t4_mem_wdata", wd1, 64'hDEADBEEF);
    cyc();
    b_req_i = 0;
    b_we_i = 0;
    #1;
    chk("t4_rvalid1_u1", {v1a, v1b}, 0);
    chk("t4_rvalid1_u2", {v2a, v2b}, 0);
    cyc();
    chk("t4_rvalid2_u2", {v2a, v2b}, 0);
    a_req_i = 1;
    a_addr_i = 14'h0007;
    #1;
    chk("t5_a_gnt", g1a, 1);
    cyc();
    rst_ni = 0;
    #1;
    chk("t5_rst_a_rvalid", v1a, 0);
    chk("t5_rst_a_gnt", g1a, 0);
    chk("t5_rst_mem_req", r1m, 0);
    chk("t5_rst_mem_addr", ad1, 0);
    chk("t5_rst_a_rdata", d1a, 0);
    cyc();
    rst_ni = 1;
    a_req_i = 0;
    #1;
    chk("t5_post_u1", {v1a, v1b}, 0);
    chk("t5_post_u2", {v2a, v2b}, 0);
    cyc();
    chk("t5_post2_u2", {v2a, v2b}, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
